// File: rtl/bfsk_demodulator_if.sv
// bfsk_demodulator_if: sample stream in, recovered bit and lock status out
interface bfsk_demodulator_if #(
   parameter int SAMPLE_W = 16,
   parameter int PERIOD_W = 10
);
   logic                sample_valid;
   logic [SAMPLE_W-1:0] sample;
   logic                bit_out;
   logic                bit_valid;
   logic                locked;
   logic [PERIOD_W-1:0] period;
   logic                err_timeout;
   modport master (output sample_valid, sample, input bit_out, bit_valid, locked, period, err_timeout);
   modport slave  (input sample_valid, sample, output bit_out, bit_valid, locked, period, err_timeout);
endinterface

// File: rtl/bfsk_demodulator.sv
// bfsk_demodulator: period-measuring BFSK receiver with hysteresis crossing detector
module bfsk_demodulator #(
   parameter int SAMPLE_W       = 16,
   parameter int MID            = 32768,
   parameter int HYST           = 1024,
   parameter int PERIOD_W       = 10,
   parameter int MIN_PERIOD     = 32,
   parameter int MAX_PERIOD     = 1023,
   parameter int THRESH         = 192,
   parameter int CYCLES_PER_BIT = 4
) (
   input  logic               CLOCK_50,
   input  logic               reset_n,
   bfsk_demodulator_if.slave  bus
);
   localparam int RUN_W = $clog2(CYCLES_PER_BIT + 1);
   localparam logic [1:0] SEARCH  = 2'd0;
   localparam logic [1:0] MEASURE = 2'd1;
   localparam logic [1:0] TRACK   = 2'd2;
   localparam logic [SAMPLE_W-1:0] HI_TH = SAMPLE_W'(MID + HYST);
   localparam logic [SAMPLE_W-1:0] LO_TH = SAMPLE_W'(MID - HYST);
   localparam logic [PERIOD_W-1:0] MAX_C = PERIOD_W'(MAX_PERIOD);
   localparam logic [PERIOD_W-1:0] MIN_C = PERIOD_W'(MIN_PERIOD);
   localparam logic [PERIOD_W-1:0] THR_C = PERIOD_W'(THRESH);
   localparam logic [RUN_W-1:0]    CPB   = RUN_W'(CYCLES_PER_BIT);

   logic [1:0]          state_q, state_d;
   logic                hi_q, hi_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic                run_cls_q, run_cls_d;
   logic [RUN_W-1:0]    run_len_q, run_len_d, run_nxt;
   logic                bit_out_q, bit_out_d;
   logic                bit_valid_q, bit_valid_d;
   logic                locked_q, locked_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                err_q, err_d;
   logic                acc, above, below, xing, busy, timeout, good, cls;

   // Crossing detection, period classification and run counting for the current sample
   always_comb begin
      acc         = bus.sample_valid;
      above       = bus.sample >= HI_TH;
      below       = bus.sample <= LO_TH;
      hi_d        = acc ? (above ? 1'b1 : below ? 1'b0 : hi_q) : hi_q;
      xing        = acc & above & ~hi_q;
      busy        = state_q != SEARCH;
      cnt_inc     = (cnt_q == MAX_C) ? MAX_C : cnt_q + 1'b1;
      timeout     = acc & busy & (cnt_inc == MAX_C);
      good        = xing & busy & ~timeout & (cnt_inc >= MIN_C);
      cls         = cnt_inc < THR_C;
      run_nxt     = (cls == run_cls_q) ? run_len_q + 1'b1 : RUN_W'(1);
      state_d     = state_q;
      cnt_d       = cnt_q;
      run_cls_d   = run_cls_q;
      run_len_d   = run_len_q;
      bit_out_d   = bit_out_q;
      bit_valid_d = 1'b0;
      locked_d    = locked_q;
      period_d    = period_q;
      err_d       = 1'b0;
      if (acc && !busy) begin
         cnt_d   = xing ? '0 : cnt_q;
         state_d = xing ? MEASURE : SEARCH;
      end else if (timeout) begin
         err_d     = 1'b1;
         locked_d  = 1'b0;
         run_cls_d = 1'b0;
         run_len_d = '0;
         cnt_d     = '0;
         state_d   = SEARCH;
      end else if (good) begin
         period_d    = cnt_inc;
         locked_d    = 1'b1;
         cnt_d       = '0;
         state_d     = TRACK;
         run_cls_d   = cls;
         bit_valid_d = run_nxt == CPB;
         bit_out_d   = (run_nxt == CPB) ? cls : bit_out_q;
         run_len_d   = (run_nxt == CPB) ? '0 : run_nxt;
      end else if (acc) begin
         cnt_d = cnt_inc;
      end
   end

   // State and registered outputs; reset takes effect immediately
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= SEARCH;
         hi_q        <= 1'b0;
         cnt_q       <= '0;
         run_cls_q   <= 1'b0;
         run_len_q   <= '0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         locked_q    <= 1'b0;
         period_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         cnt_q       <= cnt_d;
         run_cls_q   <= run_cls_d;
         run_len_q   <= run_len_d;
         bit_out_q   <= bit_out_d;
         bit_valid_q <= bit_valid_d;
         locked_q    <= locked_d;
         period_q    <= period_d;
         err_q       <= err_d;
      end
   end

   assign bus.bit_out     = bit_out_q;
   assign bus.bit_valid   = bit_valid_q;
   assign bus.locked      = locked_q;
   assign bus.period      = period_q;
   assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_bfsk_demodulator.sv
// tb_bfsk_demodulator: scoreboard bench with an index-based reference model
module tb_bfsk_demodulator;
   localparam int MID = 32768, HYST = 1024, MINP = 32, MAXP = 1023, THR = 192, CPB = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   bfsk_demodulator_if #(.SAMPLE_W(16), .PERIOD_W(10)) bus ();
   bfsk_demodulator dut (.CLOCK_50(clk), .reset_n(rst_n), .bus(bus));

   int total = 0, bad = 0, n_bits = 0, n_err = 0, ph = 0;
   logic last_bit = 1'b0;
   logic [13:0] q[$];
   logic [13:0] exp_v = '0, last_exp = '0;
   bit m_hi, m_trk;
   int m_idx, m_last, m_cls, m_len;

   function automatic logic [13:0] dut_vec();
      return {bus.bit_out, bus.bit_valid, bus.locked, bus.period, bus.err_timeout};
   endfunction

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: periods are differences of accepted-sample indices between rising crossings
   task automatic model(input logic [15:0] s);
      bit rise;
      int p, c;
      m_idx++;
      rise = !m_hi && int'(s) >= MID + HYST;
      if (int'(s) >= MID + HYST) m_hi = 1;
      else if (int'(s) <= MID - HYST) m_hi = 0;
      exp_v[12] = 1'b0;
      exp_v[0]  = 1'b0;
      if (m_trk) begin
         p = m_idx - m_last;
         if (p >= MAXP) begin
            exp_v[0] = 1'b1; exp_v[11] = 1'b0;
            m_trk = 0; m_cls = 0; m_len = 0;
         end else if (rise && p >= MINP) begin
            c = (p < THR) ? 1 : 0;
            exp_v[10:1] = 10'(p);
            exp_v[11] = 1'b1;
            m_last = m_idx;
            m_len = (c == m_cls) ? m_len + 1 : 1;
            m_cls = c;
            if (m_len == CPB) begin
               exp_v[13] = 1'(c); exp_v[12] = 1'b1; m_len = 0;
            end
         end
      end else if (rise) begin
         m_trk = 1; m_last = m_idx;
      end
      q.push_back(exp_v);
   endtask

   task automatic drive(input bit v, input logic [15:0] s);
      @(negedge clk);
      bus.sample_valid = v;
      bus.sample = s;
      if (v) model(s);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 16'h0);
   endtask

   function automatic logic [15:0] sine();
      int nz;
      nz = int'($urandom_range(0, 400)) - 200;
      return 16'(MID + $rtoi(30000.0 * $sin(6.283185307179586 * real'(ph) / 256.0)) + nz);
   endfunction

   task automatic tone(input int stepv, input int n, input bit gap);
      for (int i = 0; i < n; i++) begin
         if (gap) begin
            drive(0, 16'($urandom));
            drive(0, 16'($urandom));
         end
         drive(1, sine());
         ph = (ph + stepv) % 256;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.sample_valid = 1'b0;
      #1;
      chk("reset_outputs", int'(dut_vec()), 0);
      q.delete();
      m_hi = 0; m_trk = 0; m_idx = 0; m_last = 0; m_cls = 0; m_len = 0;
      exp_v = '0; ph = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: one response expected after every accepted sample, pulses low otherwise
   initial begin
      logic acc, in_rst;
      logic [13:0] act, e;
      wait (rst_n == 1'b0);
      forever begin
         @(posedge clk);
         acc = bus.sample_valid && rst_n;
         in_rst = !rst_n;
         #1;
         act = dut_vec();
         if (in_rst) last_exp = '0;
         else if (acc) begin
            if (q.size() == 0) chk("scoreboard_underflow", 0, 1);
            else begin
               e = q.pop_front();
               chk("sample_response", int'(act), int'(e));
               last_exp = e;
            end
         end else chk("idle_hold", int'(act), int'(last_exp & ~14'h1001));
         if (!in_rst && act[12]) begin n_bits++; last_bit = act[13]; end
         if (!in_rst && act[0]) n_err++;
      end
   end

   initial begin
      int b0, e0;
      bus.sample_valid = 1'b0;
      bus.sample = '0;
      do_reset();
      // period 256: lock at 2nd crossing, one space bit within 8 crossings
      b0 = n_bits;
      tone(1, 2048, 0);
      idle(2);
      chk("t1_period", int'(bus.period), 256);
      chk("t1_locked", int'(bus.locked), 1);
      chk("t1_bits", n_bits - b0, 1);
      chk("t1_bit", int'(last_bit), 0);
      // period 128: mark bits
      tone(2, 2048, 0);
      idle(2);
      chk("t2_period", int'(bus.period), 128);
      chk("t2_bit", int'(last_bit), 1);
      // two space periods then mark: first bit is a 1 after four mark periods
      do_reset();
      b0 = n_bits;
      tone(1, 516, 0);
      tone(2, 560, 0);
      idle(2);
      chk("t3_bits", n_bits - b0, 1);
      chk("t3_bit", int'(last_bit), 1);
      // glitch crossing shortly after a real one is ignored
      do_reset();
      tone(1, 1034, 0);
      drive(1, 16'd0);
      drive(1, 16'd65535);
      ph = (ph + 2) % 256;
      tone(1, 300, 0);
      idle(2);
      chk("t4_period", int'(bus.period), 256);
      chk("t4_locked", int'(bus.locked), 1);
      // flat midscale: exactly one timeout
      e0 = n_err;
      repeat (1100) drive(1, 16'd32768);
      idle(2);
      chk("t5_timeouts", n_err - e0, 1);
      chk("t5_locked", int'(bus.locked), 0);
      tone(1, 600, 0);
      // sparse sample_valid counts only accepted samples
      do_reset();
      tone(1, 1500, 1);
      idle(2);
      chk("t6_period", int'(bus.period), 256);
      tone(1, 700, 1);
      do_reset();
      b0 = n_bits;
      tone(1, 2048, 0);
      idle(2);
      chk("t6_relock_period", int'(bus.period), 256);
      chk("t6_relock_bits", n_bits - b0, 1);
      // random segments of tones, gaps and flat in-band holds
      for (int k = 0; k < 8; k++) begin
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(0, 1100)) drive(1, 16'(MID - 900 + int'($urandom_range(0, 1800))));
         tone(int'($urandom_range(1, 2)), int'($urandom_range(200, 900)), 1'($urandom_range(0, 1)));
      end
      idle(3);
      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
